pci_debug_responder: RTL and testbench

PCI_DEBUG_RESPONDER -- requirements
Module: pci_debug_responder

---
 rtl/pci_debug_responder_pkg.sv | 21 ++
 rtl/pci_debug_responder_if.sv | 30 +++
 rtl/debug_ring_ram.sv | 31 +++
 rtl/pci_debug_responder.sv | 161 ++++++++++++++++
 tb/tb_pci_debug_responder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_debug_responder_pkg.sv
// Shared types for the PCI debug responder: cache line type, default depth, FSM state enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional feature macro used by the design: PCI_DEBUG_RESP_TIMESTAMP_EN.
package pci_debug_responder_pkg;

    // Capture/read line width; the responder's WIDTH parameter defaults to $bits(cache_line_t).
    localparam int LINE_W            = 512;
    // Ring holds 2**DEFAULT_LOG_DEPTH lines unless overridden.
    localparam int DEFAULT_LOG_DEPTH = 10;

    typedef logic [LINE_W-1:0] cache_line_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } pci_debug_resp_state_t;

endpackage

// File: rtl/pci_debug_responder_if.sv
// Capture + debug-read bus between tile/arbiter (master) and the debug responder (slave).
// Latency: n/a (wires only).
// Backpressure: read beats use rvalid/rready; read requests and captures have no ready.
//
// Signals: wvalid/wdata capture request; arvalid/arlen one-cycle read request (burst
// length minus one); rvalid/rdata/rlast read beat; rready beat acceptance.
interface pci_debug_responder_if
    import pci_debug_responder_pkg::*;
#(
    parameter int WIDTH = $bits(cache_line_t)
);
    logic             wvalid;
    logic [WIDTH-1:0] wdata;
    logic             arvalid;
    logic [7:0]       arlen;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             rlast;
    logic             rready;

    modport master (
        output wvalid, wdata, arvalid, arlen, rready,
        input  rvalid, rdata, rlast
    );

    modport slave (
        input  wvalid, wdata, arvalid, arlen, rready,
        output rvalid, rdata, rlast
    );
endinterface

// File: rtl/debug_ring_ram.sv
// Simple dual-port line storage for the debug ring (one write port, one read port).
// Latency: 1 cycle, read data registered on re_i; output holds when re_i is low.
// Backpressure: none; contents are never cleared, including by reset.
//
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i/rdata_o read port.
module debug_ring_ram #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [LOG_DEPTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [LOG_DEPTH-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);
    logic [WIDTH-1:0] mem_q [0:(2**LOG_DEPTH)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/pci_debug_responder.sv
// Debug capture ring: tiles push lines, the PCI arbiter drains them in bursts of arlen+1 beats.
// Latency: first beat 2 cycles after arvalid, then one FETCH cycle between beats.
// Backpressure: beat held stable until rready; captures into a full ring are dropped and counted.
//
// Ports: clk, rst (sync, active-high); bus (slave modport: capture, read request, read beats);
// size = occupancy in lines; drop_count = saturating count of dropped captures.
// Macro PCI_DEBUG_RESP_TIMESTAMP_EN: stamp a free-running cycle count into the top 32 bits
// of every captured line; when undefined, lines are stored as given and no counter exists.
module pci_debug_responder
    import pci_debug_responder_pkg::*;
#(
    parameter int WIDTH     = $bits(cache_line_t),
    parameter int LOG_DEPTH = DEFAULT_LOG_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    pci_debug_responder_if.slave bus,
    output logic [LOG_DEPTH:0]   size,
    output logic [31:0]          drop_count
);
    localparam logic [LOG_DEPTH:0]   CNT_FULL = {1'b1, {LOG_DEPTH{1'b0}}};
    localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

    pci_debug_resp_state_t state_q, state_d;
    logic [8:0]            rem_q, rem_d;
    logic                  has_line_q, has_line_d;   // current beat carries a real line
    logic [LOG_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]    count_q, count_d;
    logic [31:0]           drop_q, drop_d;

    logic                  accept;
    logic                  pop;
    logic                  wr_en;
    logic                  wr_drop;
    logic                  ram_re;
    logic [WIDTH-1:0]      ram_rdata;
    logic [WIDTH-1:0]      wr_line;

`ifdef PCI_DEBUG_RESP_TIMESTAMP_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign wr_line = {cycle_q, bus.wdata[WIDTH-33:0]};
`else
    assign wr_line = bus.wdata;
`endif

    // Fullness uses the pre-cycle count, so a same-cycle pop never rescues a capture.
    assign wr_en   = bus.wvalid && (count_q != CNT_FULL);
    assign wr_drop = bus.wvalid && (count_q == CNT_FULL);
    assign accept  = (state_q == ST_SEND) && bus.rready;
    assign pop     = accept && has_line_q;

    // Ring bookkeeping; pointers wrap naturally at LOG_DEPTH bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (wr_drop && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end
    end

    // Read FSM. The RAM's registered output doubles as the beat register: it is only
    // reloaded in FETCH, so it stays stable for the whole SEND stall.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        has_line_d = has_line_q;
        ram_re     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.arvalid) begin
                    rem_d   = {1'b0, bus.arlen} + 9'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A line written this very cycle into an empty ring is not visible yet;
                // the beat goes out as zero padding.
                ram_re     = 1'b1;
                has_line_d = (count_q != '0);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.rready) begin
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        has_line_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            has_line_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            has_line_q <= has_line_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    debug_ring_ram #(
        .WIDTH     (WIDTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_line),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign bus.rvalid = (state_q == ST_SEND);
    assign bus.rlast  = (state_q == ST_SEND) && (rem_q == 9'd1);
    assign bus.rdata  = has_line_q ? ram_rdata : '0;
    assign size       = count_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_pci_debug_responder.sv
// Bench for pci_debug_responder: random captures/bursts against a queue-based ring model.
// Latency: checks first beat 2 cycles after arvalid; beats scored by a decoupled monitor.
// Backpressure: rready driven always-high, random, or held low by the stimulus.
//
// Macro PCI_DEBUG_RESP_TIMESTAMP_EN: top 32 bits are masked in data checks and a
// timestamp-spacing test is added.
module tb_pci_debug_responder;
    import pci_debug_responder_pkg::*;

    localparam int W     = 512;
    localparam int LD    = 10;
    localparam int DEPTH = 2**LD;

`ifdef PCI_DEBUG_RESP_TIMESTAMP_EN
    localparam logic [W-1:0] CMP_MASK = {32'h0, {(W-32){1'b1}}};
`else
    localparam logic [W-1:0] CMP_MASK = {W{1'b1}};
`endif

    typedef struct {
        logic [W-1:0] dat;
        bit           last;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [LD:0]   size;
    logic [31:0]   drop_count;

    pci_debug_responder_if #(.WIDTH(W)) bus();

    pci_debug_responder #(
        .WIDTH     (W),
        .LOG_DEPTH (LD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .size       (size),
        .drop_count (drop_count)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model[$];     // reference ring contents, oldest first
    int           exp_drops = 0;
    beat_t        exp_q[$];     // scoreboard of expected beats
    logic [W-1:0] got_q[$];     // raw accepted beats
    int           rr_mode = 0;  // 0: rready high, 1: random, 2: stimulus-owned

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] l;
        l = '0;
        for (int i = 0; i < W/32; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    // rready driver
    always @(posedge clk) begin
        #1;
        if (rr_mode == 1) bus.rready = 1'($urandom_range(0, 1));
        else if (rr_mode == 0) bus.rready = 1'b1;
    end

    // Monitor: scores every accepted beat and checks stability during stalls.
    logic [W-1:0] hold_dat;
    logic         hold_last;
    bit           hold_vld = 0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_vld = 0;
        end else begin
            if (hold_vld) begin
                checks++;
                if (!(bus.rvalid === 1'b1 && bus.rdata === hold_dat && bus.rlast === hold_last)) begin
                    errors++;
                    $display("FAIL stall_stable: rvalid=%0b rlast=%0b (held %0b) rdata=%h held=%h",
                             bus.rvalid, bus.rlast, hold_last, bus.rdata, hold_dat);
                end
            end
            if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
                got_q.push_back(bus.rdata);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got rdata=%h with nothing expected", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ((bus.rdata & CMP_MASK) !== (e.dat & CMP_MASK) || bus.rlast !== e.last) begin
                        errors++;
                        $display("FAIL beat: got rlast=%0b rdata=%h expected rlast=%0b rdata=%h",
                                 bus.rlast, bus.rdata, e.last, e.dat);
                    end
                end
            end
            hold_vld  = (bus.rvalid === 1'b1) && (bus.rready !== 1'b1);
            hold_dat  = bus.rdata;
            hold_last = bus.rlast;
        end
    end

    // Capture n lines while no burst is in flight (1-2 cycles per line).
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = rand_line();
            if (model.size() < DEPTH) model.push_back(bus.wdata);
            else exp_drops++;
            @(posedge clk); #1;
            bus.wvalid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Issue a burst from IDLE; nw cycles of random captures run alongside. Callers only
    // allow nw>0 when the ring already holds the whole burst and cannot overflow.
    task automatic issue_burst(input int alen, input int nw);
        beat_t b;
        for (int i = 0; i <= alen; i++) begin
            if (model.size() > 0) b.dat = model.pop_front();
            else b.dat = '0;
            b.last = (i == alen);
            exp_q.push_back(b);
        end
        bus.arvalid = 1'b1;
        bus.arlen   = 8'(alen);
        fork
            begin
                @(posedge clk); #1;
                bus.arvalid = 1'b0;
                chk("lat_fetch_rvalid", 64'(bus.rvalid), 64'd0);
                @(posedge clk); #1;
                chk("lat_send_rvalid", 64'(bus.rvalid), 64'd1);
            end
            begin
                for (int k = 0; k < nw; k++) begin
                    bus.wvalid = 1'($urandom_range(0, 1));
                    bus.wdata  = rand_line();
                    if (bus.wvalid) model.push_back(bus.wdata);
                    @(posedge clk); #1;
                end
                bus.wvalid = 1'b0;
            end
        join
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model.delete();
        exp_q.delete();
        exp_drops = 0;
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.arvalid = 1'b0;
        bus.arlen   = '0;
        bus.rready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rlast", 64'(bus.rlast), 64'd0);
        chk("rst_rdata_zero", 64'(bus.rdata == '0), 64'd1);
        chk("rst_size", 64'(size), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;

        // Empty ring: two zero beats, last on the second.
        issue_burst(1, 0);
        drain();
        chk("empty_size", 64'(size), 64'd0);

        // Three lines out in order.
        capture(3);
        chk("abc_size_before", 64'(size), 64'd3);
        issue_burst(2, 0);
        drain();
        chk("abc_size_after", 64'(size), 64'd0);

        // Beat held for 10 cycles with rready low: no pop until accepted.
        capture(1);
        rr_mode    = 2;
        bus.rready = 1'b0;
        issue_burst(0, 0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("stall_rvalid", 64'(bus.rvalid), 64'd1);
        chk("stall_size", 64'(size), 64'd1);
        bus.rready = 1'b1;
        drain();
        chk("stall_size_after", 64'(size), 64'd0);

        // Random mix of captures and bursts, some with concurrent captures.
        for (int it = 0; it < 40; it++) begin
            int op;
            int alen;
            int nw;
            op      = $urandom_range(0, 2);
            rr_mode = $urandom_range(0, 1);
            if (op == 0) begin
                capture($urandom_range(1, 12));
            end else begin
                alen = (op == 1) ? $urandom_range(0, 7) : $urandom_range(0, 20);
                nw   = 0;
                if (op == 1 && model.size() >= alen + 1 && model.size() + 8 <= DEPTH)
                    nw = $urandom_range(0, 8);
                issue_burst(alen, nw);
                drain();
            end
            chk("rand_size", 64'(size), 64'(model.size()));
            chk("rand_drops", 64'(drop_count), 64'(exp_drops));
        end

        // Fill to capacity plus five drops, then read the oldest line.
        reset_dut();
        rr_mode = 0;
        capture(DEPTH + 5);
        chk("fill_size", 64'(size), 64'(DEPTH));
        chk("fill_drops", 64'(drop_count), 64'd5);
        issue_burst(0, 0);
        drain();
        chk("fill_size_after", 64'(size), 64'(DEPTH - 1));

        // Reset after the first of four beats.
        reset_dut();
        rr_mode = 0;
        capture(4);
        issue_burst(3, 0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_first_beat_seen", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("midrst_size", 64'(size), 64'd0);
        rst = 1'b0;
        model.delete();
        exp_q.delete();
        exp_drops = 0;
        issue_burst(0, 0);
        drain();
        chk("midrst_size_after", 64'(size), 64'd0);

`ifdef PCI_DEBUG_RESP_TIMESTAMP_EN
        // Two captures seven cycles apart carry timestamps seven apart.
        reset_dut();
        rr_mode = 0;
        got_q.delete();
        bus.wvalid = 1'b1;
        bus.wdata  = rand_line();
        model.push_back(bus.wdata);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b1;
        bus.wdata  = rand_line();
        model.push_back(bus.wdata);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        issue_burst(1, 0);
        drain();
        chk("ts_beats", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2)
            chk("ts_delta", 64'(got_q[1][W-1 -: 32] - got_q[0][W-1 -: 32]), 64'd7);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
